// File: rtl/md_pkg.sv
// Shared encodings and default latencies for the multiply/divide scheduler.
package md_pkg;

    // E-stage md operation encodings; anything outside this set acts as MD_NONE.
    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8
    } md_op_e;

    typedef enum logic {
        StIdle,
        StRun
    } md_state_e;

    localparam int unsigned MD_MULT_CYCLES = 5;
    localparam int unsigned MD_DIV_CYCLES  = 10;

    // Ops that occupy the unit for a multi-cycle busy period.
    function automatic logic is_long_op(logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_div_op(logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_sched_if.sv
// E/D-stage handshake between the pipeline and the md scheduler.
interface md_sched_if;
    logic [3:0]  md_op_E;
    logic [31:0] rs_val_E;
    logic [31:0] rt_val_E;
    logic        md_use_D;
    logic        busy;
    logic        start;
    logic        stall_md_D;
    logic [31:0] md_rdata_E;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output md_op_E, rs_val_E, rt_val_E, md_use_D,
        input  busy, start, stall_md_D, md_rdata_E, hi, lo
    );

    modport slave (
        input  md_op_E, rs_val_E, rt_val_E, md_use_D,
        output busy, start, stall_md_D, md_rdata_E, hi, lo
    );
endinterface

// File: rtl/md_alu.sv
// Combinational 64-bit {hi,lo} result for MULT/MULTU/DIV/DIVU; other ops pass hi/lo through.
module md_alu
    import md_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [63:0] result
);

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] quot_s;
    logic        [31:0] rem_s;
    logic        [31:0] quot_u;
    logic        [31:0] rem_u;
    logic               div_ovf;

    // Compute every candidate, then select by op; divide-by-zero keeps the current hi/lo.
    always_comb begin
        prod_s  = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
        prod_u  = {32'h0, rs} * {32'h0, rt};
        quot_s  = $signed(rs) / $signed(rt);
        rem_s   = $signed(rs) % $signed(rt);
        quot_u  = rs / rt;
        rem_u   = rs % rt;
        // Most-negative / -1 overflows 32 bits; pin the architectural result.
        div_ovf = (rs == 32'h8000_0000) && (rt == 32'hFFFF_FFFF);

        result = {hi, lo};
        case (op)
            MD_MULT:  result = prod_s;
            MD_MULTU: result = prod_u;
            MD_DIV: begin
                if (rt != 32'h0) begin
                    result = div_ovf ? {32'h0, 32'h8000_0000} : {rem_s, quot_s};
                end
            end
            MD_DIVU: begin
                if (rt != 32'h0) begin
                    result = {rem_u, quot_u};
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_sched.sv
// Multiply/divide scheduler: owns HI/LO, models unit latency, and raises the D-stage stall.
module md_sched
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES
) (
    input logic       clk,
    input logic       reset_n,
    md_sched_if.slave bus
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    md_state_e       state;
    logic [CntW-1:0] count;
    logic [31:0]     pend_hi;
    logic [31:0]     pend_lo;
    logic [31:0]     hi_q;
    logic [31:0]     lo_q;
    logic            busy_q;
    logic            start;
    logic [63:0]     alu_result;

    md_alu u_alu (
        .op     (bus.md_op_E),
        .rs     (bus.rs_val_E),
        .rt     (bus.rt_val_E),
        .hi     (hi_q),
        .lo     (lo_q),
        .result (alu_result)
    );

    assign start = !busy_q && is_long_op(bus.md_op_E);

    // Start accept, stall request and HI/LO read port.
    always_comb begin
        bus.start      = start;
        bus.busy       = busy_q;
        bus.hi         = hi_q;
        bus.lo         = lo_q;
        bus.stall_md_D = bus.md_use_D && (busy_q || start);
        bus.md_rdata_E = 32'h0;
        if (bus.md_op_E == MD_MFHI) begin
            bus.md_rdata_E = hi_q;
        end else if (bus.md_op_E == MD_MFLO) begin
            bus.md_rdata_E = lo_q;
        end
    end

    // FSM: latch result on start, count down, commit to HI/LO on the last busy cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= StIdle;
            busy_q  <= 1'b0;
            count   <= '0;
            pend_hi <= 32'h0;
            pend_lo <= 32'h0;
            hi_q    <= 32'h0;
            lo_q    <= 32'h0;
        end else begin
            case (state)
                StIdle: begin
                    if (start) begin
                        {pend_hi, pend_lo} <= alu_result;
                        count  <= is_div_op(bus.md_op_E) ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
                        busy_q <= 1'b1;
                        state  <= StRun;
                    end else if (bus.md_op_E == MD_MTHI) begin
                        hi_q <= bus.rs_val_E;
                    end else if (bus.md_op_E == MD_MTLO) begin
                        lo_q <= bus.rs_val_E;
                    end
                end
                StRun: begin
                    // Every op presented while running is ignored.
                    if (count == CntW'(1)) begin
                        hi_q   <= pend_hi;
                        lo_q   <= pend_lo;
                        count  <= '0;
                        busy_q <= 1'b0;
                        state  <= StIdle;
                    end else begin
                        count <= count - CntW'(1);
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched: directed vector table, corner sequences, random vs model.
module tb_md_sched;
    import md_pkg::*;

    localparam int unsigned MultN = 5;
    localparam int unsigned DivN  = 10;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    md_sched_if bus();

    md_sched #(
        .MULT_CYCLES (MultN),
        .DIV_CYCLES  (DivN)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: committed regs, pending result, busy cycles remaining.
    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    int          m_left;

    // Last values sampled from the DUT by cycle().
    logic        s_busy, s_start, s_stall;
    logic [31:0] s_rdata, s_hi, s_lo;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] rs, rt, pre_hi, pre_lo, exp_hi, exp_lo;
        int          cycles;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Architectural result from the instruction definitions, using 64-bit arithmetic.
    function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] rs,
                                               input logic [31:0] rt, input logic [31:0] hi,
                                               input logic [31:0] lo);
        longint a, b, q, r;
        logic [63:0] res;
        res = {hi, lo};
        if (op == 4'd1) begin
            a = longint'($signed(rs));
            b = longint'($signed(rt));
            res = 64'(a * b);
        end else if (op == 4'd2) begin
            a = longint'({32'h0, rs});
            b = longint'({32'h0, rt});
            res = 64'(a * b);
        end else if ((op == 4'd3 || op == 4'd4) && rt != 32'h0) begin
            if (op == 4'd3) begin
                a = longint'($signed(rs));
                b = longint'($signed(rt));
            end else begin
                a = longint'({32'h0, rs});
                b = longint'({32'h0, rt});
            end
            q = a / b;
            r = a % b;
            res = {r[31:0], q[31:0]};
        end
        return res;
    endfunction

    task automatic model_reset();
        m_hi = 32'h0; m_lo = 32'h0; m_phi = 32'h0; m_plo = 32'h0; m_left = 0;
    endtask

    // One clock: drive inputs, sample/compare before the edge, then advance model past the edge.
    task automatic cycle(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input logic use_d, input bit chk);
        logic        m_start;
        logic [31:0] m_rd;
        bus.md_op_E  = op;
        bus.rs_val_E = rs;
        bus.rt_val_E = rt;
        bus.md_use_D = use_d;
        #2;
        m_start = (m_left == 0) && (op >= 4'd1) && (op <= 4'd4);
        m_rd    = (op == 4'd5) ? m_hi : (op == 4'd6) ? m_lo : 32'h0;
        s_busy  = bus.busy;
        s_start = bus.start;
        s_stall = bus.stall_md_D;
        s_rdata = bus.md_rdata_E;
        s_hi    = bus.hi;
        s_lo    = bus.lo;
        if (chk) begin
            check("busy", 64'(s_busy), 64'(m_left > 0));
            check("start", 64'(s_start), 64'(m_start));
            check("stall", 64'(s_stall), 64'(use_d && (m_left > 0 || m_start)));
            check("rdata", 64'(s_rdata), 64'(m_rd));
            check("hi", 64'(s_hi), 64'(m_hi));
            check("lo", 64'(s_lo), 64'(m_lo));
        end
        @(posedge clk);
        #1;
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end else if (m_start) begin
            {m_phi, m_plo} = ref_result(op, rs, rt, m_hi, m_lo);
            m_left = (op == 4'd3 || op == 4'd4) ? int'(DivN) : int'(MultN);
        end else if (op == 4'd7) begin
            m_hi = rs;
        end else if (op == 4'd8) begin
            m_lo = rs;
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        vecs[0] = '{4'd1, 32'hFFFF_FFFE, 32'd3, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
        vecs[1] = '{4'd2, 32'hFFFF_FFFE, 32'd3, 32'h0, 32'h0, 32'h0000_0002, 32'hFFFF_FFFA, 5};
        vecs[2] = '{4'd3, 32'hFFFF_FFF9, 32'd2, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        vecs[3] = '{4'd4, 32'd7, 32'd2, 32'h0, 32'h0, 32'd1, 32'd3, 10};
        vecs[4] = '{4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h9, 32'h9, 32'h0, 32'h8000_0000, 10};
        vecs[5] = '{4'd3, 32'd5, 32'd0, 32'h11, 32'h22, 32'h11, 32'h22, 10};
        vecs[6] = '{4'd4, 32'hFFFF_FFFF, 32'd0, 32'hAB, 32'hCD, 32'hAB, 32'hCD, 10};
        vecs[7] = '{4'd3, 32'd7, 32'hFFFF_FFFE, 32'h0, 32'h0, 32'd1, 32'hFFFF_FFFD, 10};
        vecs[8] = '{4'd1, 32'h8000_0000, 32'h8000_0000, 32'h0, 32'h0, 32'h4000_0000, 32'h0, 5};

        // Reset state.
        bus.md_op_E = 4'd0; bus.rs_val_E = 32'h0; bus.rt_val_E = 32'h0; bus.md_use_D = 1'b1;
        model_reset();
        #2;
        check("reset busy", 64'(bus.busy), 64'(0));
        check("reset hi", 64'(bus.hi), 64'(0));
        check("reset lo", 64'(bus.lo), 64'(0));
        check("reset stall", 64'(bus.stall_md_D), 64'(0));
        #5 reset_n = 1'b1;

        // Directed vector table.
        foreach (vecs[i]) begin
            cycle(4'd7, vecs[i].pre_hi, 32'h0, 1'b0, 1'b1);
            cycle(4'd8, vecs[i].pre_lo, 32'h0, 1'b0, 1'b1);
            cycle(vecs[i].op, vecs[i].rs, vecs[i].rt, 1'b0, 1'b1);
            check($sformatf("vec%0d start", i), 64'(s_start), 64'(1));
            cnt = 0;
            for (int k = 0; k < 40; k++) begin
                cycle(4'd0, 32'h0, 32'h0, 1'b0, 1'b1);
                if (!s_busy) break;
                cnt++;
            end
            check($sformatf("vec%0d busy cycles", i), 64'(cnt), 64'(vecs[i].cycles));
            check($sformatf("vec%0d hi", i), 64'(s_hi), 64'(vecs[i].exp_hi));
            check($sformatf("vec%0d lo", i), 64'(s_lo), 64'(vecs[i].exp_lo));
        end

        // Stall covers the start cycle plus every busy cycle, then MFLO reads the new lo.
        cycle(4'd1, 32'd9, 32'd11, 1'b1, 1'b1);
        cnt = s_stall ? 1 : 0;
        for (int k = 0; k < 20; k++) begin
            cycle(4'd0, 32'h0, 32'h0, 1'b1, 1'b1);
            if (!s_stall) break;
            cnt++;
        end
        check("stall cycles", 64'(cnt), 64'(6));
        check("stall drop lo", 64'(s_lo), 64'(99));
        cycle(4'd6, 32'h0, 32'h0, 1'b0, 1'b1);
        check("mflo after mult", 64'(s_rdata), 64'(99));

        // Second MULT while busy is ignored and does not extend the busy period.
        cycle(4'd1, 32'd6, 32'd7, 1'b0, 1'b1);
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            cycle((k == 1) ? 4'd1 : 4'd0, 32'd100, 32'd100, 1'b0, 1'b1);
            if (k == 1) check("busy mult start", 64'(s_start), 64'(0));
            if (!s_busy) break;
            cnt++;
        end
        check("busy mult cycles", 64'(cnt), 64'(5));
        check("busy mult lo", 64'(s_lo), 64'(42));
        check("busy mult hi", 64'(s_hi), 64'(0));

        // Asynchronous reset in the middle of a DIV.
        cycle(4'd7, 32'h55, 32'h0, 1'b0, 1'b1);
        cycle(4'd8, 32'h66, 32'h0, 1'b0, 1'b1);
        cycle(4'd3, 32'd100, 32'd7, 1'b0, 1'b1);
        for (int k = 0; k < 20 && m_left != 3; k++) begin
            cycle(4'd0, 32'h0, 32'h0, 1'b0, 1'b1);
        end
        check("pre-reset busy", 64'(bus.busy), 64'(1));
        reset_n = 1'b0;
        #1;
        check("async rst busy", 64'(bus.busy), 64'(0));
        check("async rst hi", 64'(bus.hi), 64'(0));
        check("async rst lo", 64'(bus.lo), 64'(0));
        model_reset();
        #1 reset_n = 1'b1;
        cycle(4'd8, 32'h5, 32'h0, 1'b0, 1'b1);
        cycle(4'd0, 32'h0, 32'h0, 1'b0, 1'b1);
        check("mtlo after reset", 64'(s_lo), 64'(5));

        // Randomized traffic, including undefined encodings and illegal ops while busy.
        for (int n = 0; n < 1500; n++) begin
            cycle(4'($urandom_range(0, 15)), pick(), pick(), 1'($urandom_range(0, 1)), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
- Multiply/divide scheduler owning the HI/LO register pair for the 5-stage MIPS pipeline.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO from the E stage and models multi-cycle latency with a countdown.
- Raises a D-stage stall request so the hazard unit freezes PC/D and bubbles E while any md-class instruction would collide with a busy unit.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU after the start cycle
- DIV_CYCLES, 10, busy cycles for DIV/DIVU after the start cycle

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset_n  input  1  asynchronous, active-low reset
- md_op_E  input  4  E-stage md operation, encodings from md_pkg; MD_NONE=0
- rs_val_E  input  32  forwarded Rs value in E
- rt_val_E  input  32  forwarded Rt value in E
- md_use_D  input  1  D-stage instruction is any md-class op
- busy  output  1  unit is counting down
- start  output  1  combinational: md_op_E is MULT/MULTU/DIV/DIVU and busy=0
- stall_md_D  output  1  md_use_D && (busy || start)
- md_rdata_E  output  32  HI for MFHI, LO for MFLO, else 0 (combinational from committed HI/LO)
- hi  output  32  committed HI
- lo  output  32  committed LO

Behaviour:
- Reset (reset_n=0, async): hi=0, lo=0, busy=0, count=0, pend_hi=0, pend_lo=0; state IDLE.
- States:
  - IDLE (busy=0)
  - RUN (busy=1, count>0)
- IDLE + start:
  - Latch pend_hi/pend_lo from the operation result.
  - Load count with MULT_CYCLES or DIV_CYCLES; go to RUN.
  - busy asserts on the cycle after start.
- Operation results:
  - MULT: signed 32x32 -> 64 {hi,lo}.
  - MULTU: unsigned 32x32 -> 64 {hi,lo}.
  - DIV: lo = signed quotient, hi = signed remainder; truncate toward zero; remainder takes the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - Divide by zero (rt_val_E=0): pend_hi=hi, pend_lo=lo, so HI/LO are unchanged at commit. The full DIV_CYCLES busy period still elapses.
  - 0x80000000 / -1 (signed): lo=0x80000000, hi=0.
- RUN:
  - count decrements each cycle.
  - When count==1: on that edge hi<=pend_hi, lo<=pend_lo, busy deasserts, go to IDLE.
  - Total latency: results are visible on hi/lo exactly N cycles after the start edge (N = MULT_CYCLES or DIV_CYCLES).
- MTHI/MTLO in IDLE: hi<=rs_val_E or lo<=rs_val_E on the next edge.
- MTHI/MTLO/MFHI/MFLO while busy are illegal. stall_md_D prevents them from ever reaching E. If presented anyway, they are ignored: no write, md_rdata_E still reflects committed HI/LO.
- Any md_op_E while busy: ignored, start=0.
- md_op_E encodings outside the defined set are treated as MD_NONE.
- MFHI/MFLO in IDLE: md_rdata_E is combinational and valid in the same cycle.
- stall_md_D also covers the start cycle itself, so a back-to-back md op in D stalls one cycle before busy rises.
- Reset mid-RUN: aborts immediately; pending result discarded; hi/lo return to 0.
- Width rules:
  - 64-bit intermediate products.
  - count width is clog2(max(MULT_CYCLES, DIV_CYCLES)+1).
  - Both parameters must be >=1. With value 1, busy is high for exactly one cycle.

Decomposition:
- md_pkg holds:
  - md_op encodings: MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MFHI=5, MD_MFLO=6, MD_MTHI=7, MD_MTLO=8.
  - Default cycle constants.
- One natural sub-module, md_alu: combinational 64-bit result from op, rs, rt, current hi/lo. This isolates signed/unsigned and divide-by-zero rules.
- md_sched keeps the FSM, counter, pending registers and stall logic.

Test Plan:
- MULT rs=0xFFFFFFFE (-2), rt=3:
  - busy=1 for 5 cycles.
  - Then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - MULTU with the same operands gives hi=0x2, lo=0xFFFFFFFA.
- DIV rs=-7, rt=2:
  - After 10 cycles, lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
  - DIVU 7/2 gives lo=3, hi=1.
- DIV by zero with hi=0x11, lo=0x22 preset via MTHI/MTLO:
  - busy for 10 cycles.
  - hi=0x11, lo=0x22 unchanged.
- md_use_D=1 during start cycle and all busy cycles:
  - stall_md_D=1 for 1+5 cycles on MULT.
  - Deasserts the cycle hi/lo commit.
  - MFLO then reads the new lo.
- Second MULT presented while busy:
  - Ignored; the first result commits on schedule.
  - No extra busy cycles.
- reset_n pulsed low at count=3 of a DIV:
  - busy=0, hi=lo=0 immediately, without waiting for a clock edge.
  - A subsequent MTLO 0x5 gives lo=5 on the next edge.
